// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and constants for the multi-port integer register file.
// Optional write-first bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_mp_if.sv
// Decode-side read ports, the two write-back ports and the issue strobe of the register file.
// The core drives through master; the register file sits on slave.
interface regfile_mp_if #(
  parameter int NRD  = 2,
  parameter int AW   = 5,
  parameter int XLEN = 32
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we0;
  logic                we1;
  logic [AW-1:0]       wa0;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd0;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  modport master (
    output rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_rd,
    input  rd_data, rd_busy
  );
  modport slave (
    input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_rd,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, issue wins over write-back.
// With REGFILE_BYPASS_EN, busy_fwd_o also hides a busy bit that is being cleared this cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = regfile_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [NREG-1:0] busy_o,
  output logic [NREG-1:0] busy_fwd_o
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_v, clr_v;

  // NOTE: every bit is assigned a default before conditional logic so no latch is inferred.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int r = 1; r < NREG; r++) begin
      set_v[r] = iss_valid && (iss_rd == AW'(r));
      clr_v[r] = (we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)));
    end
    busy_d    = set_v | (busy_q & ~clr_v);
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

`ifdef REGFILE_BYPASS_EN
  assign busy_fwd_o = busy_q & ~(clr_v & ~set_v);
`else
  assign busy_fwd_o = busy_q;
`endif
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two write-back ports (load port wins), busy scoreboard.
// Defining REGFILE_BYPASS_EN makes reads write-first for data and busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              XLEN    = regfile_pkg::XLEN,
  parameter int              NREG    = regfile_pkg::NREG,
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 'h2ffc
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy, busy_fwd;

  always_comb begin
    regs_d = regs_q;
    if (bus.we0) regs_d[bus.wa0] = bus.wd0;
    if (bus.we1) regs_d[bus.wa1] = bus.wd1;
    regs_d[0] = '0;
  end

  // NOTE: the storage is reset explicitly (SP needs a value), so it maps to flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .we0        (bus.we0),
    .wa0        (bus.wa0),
    .we1        (bus.we1),
    .wa1        (bus.wa1),
    .iss_valid  (bus.iss_valid),
    .iss_rd     (bus.iss_rd),
    .busy_o     (busy),
    .busy_fwd_o (busy_fwd)
  );

  // Raw busy is kept on the scoreboard boundary for the hazard unit; reads use the forwarded view.
  logic unused_busy;
  assign unused_busy = ^busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = bus.rd_addr[k*AW +: AW];

    always_comb begin
      data = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.we1 && (bus.wa1 == addr))      data = bus.wd1;
      else if (bus.we0 && (bus.wa0 == addr)) data = bus.wd0;
`endif
      if (addr == REG_ZERO) data = '0;
    end

    assign bus.rd_data[k*XLEN +: XLEN] = data;
    assign bus.rd_busy[k]              = busy_fwd[addr];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues expected read results, a negedge monitor compares them.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;
  localparam int AW   = 5;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  regfile_mp_if #(.NRD(NRD), .AW(AW), .XLEN(XLEN)) bus ();

  regfile_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".d0"},   bus.rd_data[0 +: XLEN],    e.d0);
      check({e.name, ".d1"},   bus.rd_data[XLEN +: XLEN], e.d1);
      check({e.name, ".busy"}, {30'd0, bus.rd_busy},      {30'd0, e.busy});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic expect_rd(input string name, input int a0, input int a1,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    exp_t e;
    bus.rd_addr = {AW'(a1), AW'(a0)};
    e.name = name; e.d0 = e0; e.d1 = e1; e.busy = eb;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Post-reset contents: only the stack pointer is non-zero.
    for (int i = 0; i < 16; i++) begin
      expect_rd($sformatf("rst_r%0d", 2*i), 2*i, 2*i+1, (2*i == 2) ? 32'h2ffc : 32'h0, 32'h0, 2'b00);
      cyc();
    end

    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hdead_beef;
    expect_rd("wr5_same", 5, 0, BYP ? 32'hdead_beef : 32'h0, 32'h0, 2'b00);
    cyc(); idle();
    expect_rd("wr5_next", 5, 0, 32'hdead_beef, 32'h0, 2'b00);
    cyc();

    bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h1;
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h2;
    expect_rd("dual7_same", 7, 5, BYP ? 32'h2 : 32'h0, 32'hdead_beef, 2'b00);
    cyc(); idle();
    expect_rd("dual7_next", 7, 5, 32'h2, 32'hdead_beef, 2'b00);
    cyc();

    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    expect_rd("iss9_same", 9, 0, 32'h0, 32'h0, 2'b00);
    cyc(); idle();
    expect_rd("iss9_busy", 9, 9, 32'h0, 32'h0, 2'b11);
    cyc();
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h99;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    expect_rd("wr_reiss9", 9, 0, BYP ? 32'h99 : 32'h0, 32'h0, 2'b01);
    cyc(); idle();
    expect_rd("reiss9_held", 9, 0, 32'h99, 32'h0, 2'b01);
    cyc();
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'haa;
    expect_rd("wb9_same", 9, 9, BYP ? 32'haa : 32'h99, BYP ? 32'haa : 32'h99, BYP ? 2'b00 : 2'b11);
    cyc(); idle();
    expect_rd("wb9_clear", 9, 9, 32'haa, 32'haa, 2'b00);
    cyc();

    bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'h44;
    cyc(); idle();
    expect_rd("wr4_notbusy", 4, 9, 32'h44, 32'haa, 2'b00);
    cyc();

    bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'h1234;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    expect_rd("r0_same", 0, 0, 32'h0, 32'h0, 2'b00);
    cyc(); idle();
    expect_rd("r0_next", 0, 4, 32'h0, 32'h44, 2'b00);
    cyc();

    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    expect_rd("pre_rst", 9, 3, 32'haa, 32'h0, 2'b00);
    cyc(); idle();
    bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h33;
    reset = 1'b1;
    expect_rd("in_rst", 9, 3, 32'haa, BYP ? 32'h33 : 32'h0, 2'b01);
    cyc(); idle();
    reset = 1'b0;
    expect_rd("after_rst_a", 9, 3, 32'h0, 32'h0, 2'b00);
    cyc();
    expect_rd("after_rst_b", 2, 5, 32'h2ffc, 32'h0, 2'b00);
    cyc();
    expect_rd("after_rst_c", 7, 4, 32'h0, 32'h0, 2'b00);
    cyc();

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
